// File: rtl/id_stage.sv
// Instruction-decode stage: 32x32 GPR file, immediate extender and ID/EX pipeline register.
// Optional macro ID_WB_FORWARD_EN adds a WB-to-ID bypass and a held-bundle refresh while stalled.
module id_stage #(
    parameter logic [5:0]  R_FORM        = 6'd0,
    parameter logic [31:0] REG_RESET_VAL = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    input  logic [31:0] Ins_in,
    input  logic        stall,
    input  logic        flush,
    input  logic        WE,
    input  logic [4:0]  Wadr,
    input  logic [31:0] Wdata,
    output logic        out_valid,
    output logic [31:0] Ins,
    output logic [31:0] Rdata1,
    output logic [31:0] Rdata2,
    output logic [31:0] Ed32,
    output logic [4:0]  Wdst
);

    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;

    function automatic logic [31:0] extend_imm(input logic [5:0] op, input logic [15:0] imm);
        logic [31:0] ext;
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: ext = {16'h0000, imm};
            OP_LUI:                   ext = {imm, 16'h0000};
            default:                  ext = {{16{imm[15]}}, imm};
        endcase
        return ext;
    endfunction

    function automatic logic [4:0] dest_reg(input logic [5:0] op, input logic [4:0] rt,
                                            input logic [4:0] rd);
        logic [4:0] dst;
        if (op == R_FORM) begin
            dst = rd;
        end else if (op == OP_JAL) begin
            dst = 5'd31;
        end else begin
            dst = rt;
        end
        return dst;
    endfunction

    logic [31:0] gpr_q [32];

    logic [5:0]  op_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [15:0] imm_s;
    logic        wb_hit_s;
    logic [31:0] read1_s;
    logic [31:0] read2_s;

    logic        valid_q,  valid_d;
    logic [31:0] ins_q,    ins_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic [31:0] rdata2_q, rdata2_d;
    logic [31:0] ed32_q,   ed32_d;
    logic [4:0]  wdst_q,   wdst_d;

    assign op_s     = Ins_in[31:26];
    assign rs_s     = Ins_in[25:21];
    assign rt_s     = Ins_in[20:16];
    assign rd_s     = Ins_in[15:11];
    assign imm_s    = Ins_in[15:0];
    assign wb_hit_s = WE && (Wadr != 5'd0);

    // Register file write-back port; $0 is never written and all entries reload on reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) begin
                gpr_q[i] <= REG_RESET_VAL;
            end
        end else if (wb_hit_s) begin
            gpr_q[Wadr] <= Wdata;
        end
    end

    // Asynchronous read ports; $0 is forced to zero regardless of the stored entry.
    always_comb begin
        read1_s = 32'h0000_0000;
        read2_s = 32'h0000_0000;
        if (rs_s != 5'd0) begin
            read1_s = gpr_q[rs_s];
        end else begin
            read1_s = 32'h0000_0000;
        end
        if (rt_s != 5'd0) begin
            read2_s = gpr_q[rt_s];
        end else begin
            read2_s = 32'h0000_0000;
        end
`ifdef ID_WB_FORWARD_EN
        if (wb_hit_s && (Wadr == rs_s)) begin
            read1_s = Wdata;
        end else begin
            read1_s = read1_s;
        end
        if (wb_hit_s && (Wadr == rt_s)) begin
            read2_s = Wdata;
        end else begin
            read2_s = read2_s;
        end
`endif
    end

    // ID/EX next state: flush beats stall, stall beats a normal load.
    always_comb begin
        valid_d  = valid_q;
        ins_d    = ins_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        ed32_d   = ed32_q;
        wdst_d   = wdst_q;
        if (flush) begin
            valid_d = 1'b0;
            ins_d   = 32'h0000_0000;
            wdst_d  = 5'd0;
        end else if (stall) begin
`ifdef ID_WB_FORWARD_EN
            // Keep a held bundle coherent with write-backs that land while it waits.
            if (valid_q && wb_hit_s && (Wadr == ins_q[25:21])) begin
                rdata1_d = Wdata;
            end else begin
                rdata1_d = rdata1_q;
            end
            if (valid_q && wb_hit_s && (Wadr == ins_q[20:16])) begin
                rdata2_d = Wdata;
            end else begin
                rdata2_d = rdata2_q;
            end
`else
            valid_d = valid_q;
`endif
        end else begin
            valid_d  = in_valid;
            rdata1_d = read1_s;
            rdata2_d = read2_s;
            ed32_d   = extend_imm(op_s, imm_s);
            if (in_valid) begin
                ins_d  = Ins_in;
                wdst_d = dest_reg(op_s, rt_s, rd_s);
            end else begin
                ins_d  = 32'h0000_0000;
                wdst_d = 5'd0;
            end
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q  <= 1'b0;
            ins_q    <= 32'h0000_0000;
            rdata1_q <= 32'h0000_0000;
            rdata2_q <= 32'h0000_0000;
            ed32_q   <= 32'h0000_0000;
            wdst_q   <= 5'd0;
        end else begin
            valid_q  <= valid_d;
            ins_q    <= ins_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            ed32_q   <= ed32_d;
            wdst_q   <= wdst_d;
        end
    end

    assign out_valid = valid_q;
    assign Ins       = ins_q;
    assign Rdata1    = rdata1_q;
    assign Rdata2    = rdata2_q;
    assign Ed32      = ed32_q;
    assign Wdst      = wdst_q;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage that produces the operand bundle consumed by the execute stage: Ins, Rdata1, Rdata2 and Ed32.
- Contains the 32x32 general-purpose register file, with two asynchronous read ports and one synchronous write-back port.
- Also contains the immediate extender and the ID/EX pipeline register, with valid/stall/flush control.
- Sits between instruction fetch (upstream) and EX (downstream); the write-back port is driven by the WB stage.

Parameters:
- R_FORM, 6'd0, opcode of R-format instructions (rd is the destination).
- REG_RESET_VAL, 32'h0, value loaded into every register-file entry on reset.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; asynchronous, active-high.
- in_valid  input  1  Ins_in carries a valid instruction this cycle.
- Ins_in  input  32  instruction from fetch.
- stall  input  1  downstream hold; the ID/EX register keeps its contents.
- flush  input  1  kill the instruction entering ID/EX (branch/jump redirect).
- WE  input  1  register-file write enable from WB.
- Wadr  input  5  write address.
- Wdata  input  32  write data.
- out_valid  output  1  the ID/EX bundle is valid.
- Ins  output  32  registered instruction.
- Rdata1  output  32  registered GPR[rs].
- Rdata2  output  32  registered GPR[rt].
- Ed32  output  32  registered extended immediate.
- Wdst  output  5  registered destination register number.

Behaviour:
- Field decode from Ins_in: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
- Extension of imm into Ed32:
  - op 0x0C, 0x0D, 0x0E (ANDI/ORI/XORI): zero-extend.
  - op 0x0F (LUI): {imm,16'h0}.
  - All other opcodes: sign-extend.
- Destination (Wdst):
  - op==R_FORM: rd.
  - op 0x03 (JAL): 5'd31.
  - Otherwise: rt.
- Register file:
  - Write happens at the rising edge when WE=1 and Wadr!=0; writes to $0 are discarded.
  - Reads of $0 always return 0.
  - Writes proceed regardless of stall or flush.
- ID/EX register, latency 1 cycle from Ins_in to outputs. At each rising edge, priority order:
  - flush=1: out_valid<=0, Ins<=0 (NOP), Wdst<=0; Rdata1/Rdata2/Ed32 hold. flush beats stall.
  - else stall=1: all outputs hold.
  - else: out_valid<=in_valid; Ins/Rdata1/Rdata2/Ed32/Wdst <= decoded values. When in_valid=0, Ins<=0 and Wdst<=0.
- Read-during-write, same edge, same register: Rdata captures the OLD array value (unless the forwarding feature is enabled).
- Reset (any time, including mid-stall):
  - All outputs 0, out_valid=0.
  - Every register-file entry set to REG_RESET_VAL; $0 still reads 0.
  - Deassertion is sampled at the next rising edge.
- No internal hazard detection; load-use stalls are generated externally via stall.

Optional Feature:
- Macro: ID_WB_FORWARD_EN.
- Defined:
  - Same-edge bypass: if WE=1, Wadr!=0 and Wadr==rs (resp. rt), Rdata1 (resp. Rdata2) captures Wdata instead of the array value.
  - Held-bundle update: while stalled with out_valid=1, a WB write whose Wadr matches the held instruction's rs/rt (nonzero) updates the held Rdata1/Rdata2 with Wdata.
- Undefined: no bypass; stale values are captured and held. The upstream must insert bubbles or rely on an EX-side forwarder.

Test Plan:
- Reset then write: WE=1, Wadr=5, Wdata=32'h1234_5678; next cycle ADD $3,$5,$0 (Ins_in=32'h00A01820) valid -> after 1 cycle out_valid=1, Rdata1=32'h12345678, Rdata2=0, Wdst=3.
- Extension: ADDI imm 16'hFFF0 -> Ed32=32'hFFFFFFF0. ORI imm 16'hFFF0 -> Ed32=32'h0000FFF0. LUI imm 16'h00AB -> Ed32=32'h00AB0000, Wdst=rt.
- $0 protection: WE=1, Wadr=0, Wdata=32'hDEADBEEF; then read rs=0 -> Rdata1=0.
- Stall/flush: valid instruction captured; stall=1 for 3 cycles with new Ins_in -> outputs unchanged. Assert flush and stall together -> out_valid=0, Ins=0.
- Same-edge read/write of $7 (old 32'h1, Wdata 32'h2) while reading rs=7 -> Rdata1=32'h1 without ID_WB_FORWARD_EN, 32'h2 with it. With the macro, a stalled bundle with rt=7 also updates Rdata2 to 32'h2 on the write.
- Mid-operation reset: assert RST asynchronously between edges while out_valid=1 -> all outputs 0 immediately. All GPRs read 0 after release.
